ebus_xfer: RTL and testbench

- EBOX-side EBUS cycle controller, directly downstream of the EDP.
- Sequences one CS/FUNC/DEMAND/XFER handshake per request.
- On writes, enables EDP AD onto EBUS through the EDP's adToEBUS_L/R inputs.
- On reads, captures device data into a holding register that feeds the EDP EBUS input.

---
 rtl/ebus_xfer.sv | 180 ++++++++++++++++++
 tb/tb_ebus_xfer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_xfer.sv
// EBOX-side EBUS cycle controller.
// Runs one CS/FUNC -> DEMAND -> XFER handshake per accepted request. Writes
// enable the EDP AD halves onto EBUS; reads capture device data into rdData.
// Ports:
//   eboxClk, eboxReset_n      clock, async active-low reset
//   req, isWrite, func, ctlNum request and its fields (sampled in IDLE)
//   busy, done, timeout        status (done/timeout are one-cycle pulses)
//   adToEBUS_L, adToEBUS_R     EDP AD drive enables (writes only)
//   EBUS_CS, EBUS_FUNC         controller select / function onto EBUS
//   EBUS_DEMAND                demand strobe
//   EBUS_XFER, EBUS_D          device acknowledge (async) and data
//   rdData                     last successfully read word
module ebus_xfer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        eboxClk,
  input  logic        eboxReset_n,
  input  logic        req,
  input  logic        isWrite,
  input  logic [0:2]  func,
  input  logic [0:6]  ctlNum,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        adToEBUS_L,
  output logic        adToEBUS_R,
  output logic [0:6]  EBUS_CS,
  output logic [0:2]  EBUS_FUNC,
  output logic        EBUS_DEMAND,
  input  logic        EBUS_XFER,
  input  logic [0:35] EBUS_D,
  output logic [0:35] rdData
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DEMAND, S_RELEASE, S_DONE, S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [0:2]       func_q, func_d;
  logic [0:6]       ctl_q, ctl_d;
  logic             xfer_s1, xfer_s;
  logic             capture_c;
  logic             hold_c;

  logic       busy_d, done_d, timeout_d, ad_en_d, demand_d;
  logic [0:6] cs_d;
  logic [0:2] func_out_d;

  // Next state, counter, request latch and next registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    func_d    = func_q;
    ctl_d     = ctl_q;
    capture_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = isWrite;
          func_d  = func;
          ctl_d   = ctlNum;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_DEMAND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DEMAND: begin
        if (xfer_s) begin
          capture_c = ~wr_q;
          cnt_d     = '0;
          state_d   = S_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (!xfer_s) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so they register with it
    hold_c     = (state_d == S_SETUP) || (state_d == S_DEMAND) || (state_d == S_RELEASE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    timeout_d  = (state_d == S_ABORT);
    demand_d   = (state_d == S_DEMAND);
    ad_en_d    = hold_c & wr_d;
    cs_d       = hold_c ? ctl_d  : '0;
    func_out_d = hold_c ? func_d : '0;
  end

  // State, counter and latched request fields
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      func_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      func_q  <= func_d;
      ctl_q   <= ctl_d;
    end
  end

  // Two-flop synchronizer for the device acknowledge
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      xfer_s1 <= 1'b0;
      xfer_s  <= 1'b0;
    end else begin
      xfer_s1 <= EBUS_XFER;
      xfer_s  <= xfer_s1;
    end
  end

  // Registered outputs
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      adToEBUS_L  <= 1'b0;
      adToEBUS_R  <= 1'b0;
      EBUS_CS     <= '0;
      EBUS_FUNC   <= '0;
      EBUS_DEMAND <= 1'b0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      timeout     <= timeout_d;
      adToEBUS_L  <= ad_en_d;
      adToEBUS_R  <= ad_en_d;
      EBUS_CS     <= cs_d;
      EBUS_FUNC   <= func_out_d;
      EBUS_DEMAND <= demand_d;
    end
  end

  // Read data is taken on the edge that leaves DEMAND with the acknowledge seen
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      rdData <= '0;
    end else if (capture_c) begin
      rdData <= EBUS_D;
    end
  end

endmodule

// File: tb/tb_ebus_xfer.sv
module tb_ebus_xfer;

  localparam int unsigned SETUP = 2;
  localparam int unsigned TMO   = 16;
  localparam int MODE_OK    = 0;  // device acks, drops one cycle after DEMAND falls
  localparam int MODE_NEVER = 1;  // device never acks
  localparam int MODE_STUCK = 2;  // device acks and holds XFER until controller idles

  logic        eboxClk = 1'b0;
  logic        eboxReset_n = 1'b0;
  logic        req = 1'b0;
  logic        isWrite = 1'b0;
  logic [0:2]  func = '0;
  logic [0:6]  ctlNum = '0;
  logic        busy, done, timeout, adToEBUS_L, adToEBUS_R, EBUS_DEMAND;
  logic [0:6]  EBUS_CS;
  logic [0:2]  EBUS_FUNC;
  logic        EBUS_XFER = 1'b0;
  logic [0:35] EBUS_D = '0;
  logic [0:35] rdData;

  ebus_xfer #(.SETUP_CYCLES(SETUP), .TIMEOUT(TMO)) dut (
    .eboxClk(eboxClk), .eboxReset_n(eboxReset_n), .req(req), .isWrite(isWrite),
    .func(func), .ctlNum(ctlNum), .busy(busy), .done(done), .timeout(timeout),
    .adToEBUS_L(adToEBUS_L), .adToEBUS_R(adToEBUS_R), .EBUS_CS(EBUS_CS),
    .EBUS_FUNC(EBUS_FUNC), .EBUS_DEMAND(EBUS_DEMAND), .EBUS_XFER(EBUS_XFER),
    .EBUS_D(EBUS_D), .rdData(rdData)
  );

  always #5 eboxClk = ~eboxClk;

  typedef struct {
    bit        wr;
    bit [2:0]  fn;
    bit [6:0]  ctl;
    bit        to;
    bit [35:0] rd;
    int        dem;
    int        rel;
  } exp_t;

  exp_t      expq[$];
  int        errors = 0;
  int        checks = 0;
  bit [35:0] model_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome and phase lengths from the handshake rules
  function automatic exp_t predict(input bit wr, input bit [2:0] fn, input bit [6:0] ctl,
                                   input int mode, input bit [35:0] data);
    exp_t e;
    e.wr  = wr;
    e.fn  = fn;
    e.ctl = ctl;
    e.to  = (mode != MODE_OK);
    // DEMAND: ack seen in first cycle, +2 sync stages => 3 cycles; no ack => full timeout
    e.dem = (mode == MODE_NEVER) ? int'(TMO) : 3;
    // RELEASE: 1 cycle before device drops, +2 sync, +1 decide => 4; stuck => timeout
    e.rel = (mode == MODE_OK) ? 4 : (mode == MODE_STUCK) ? int'(TMO) : 0;
    if (!wr && mode != MODE_NEVER) model_rd = data;
    e.rd = model_rd;
    return e;
  endfunction

  // Device model
  int        dev_mode = MODE_OK;
  bit [35:0] dev_data = '0;
  bit        raised = 1'b0;
  bit        fell = 1'b0;

  always @(posedge eboxClk) begin
    #1;
    if (!busy) begin
      raised    = 1'b0;
      fell      = 1'b0;
      EBUS_XFER = 1'b0;
      EBUS_D    = 36'({$urandom, $urandom});
    end else if (dev_mode != MODE_NEVER) begin
      if (!raised && EBUS_DEMAND) begin
        raised    = 1'b1;
        EBUS_XFER = 1'b1;
        EBUS_D    = dev_data;
      end else if (raised && dev_mode == MODE_OK) begin
        if (fell) EBUS_XFER = 1'b0;
        else if (!EBUS_DEMAND) fell = 1'b1;
      end
    end
  end

  // Monitor: measures each transfer's phases and compares at its completion pulse
  int set_n = 0, dem_n = 0, rel_n = 0;

  always @(negedge eboxClk) begin : mon
    exp_t e;
    if (!eboxReset_n) begin
      set_n = 0; dem_n = 0; rel_n = 0;
    end else if (done || timeout) begin
      chk("done_and_timeout", 64'(done & timeout), 64'(0));
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b timeout=%0b expected no transfer", done, timeout);
      end else begin
        e = expq.pop_front();
        chk("timeout_pulse", 64'(timeout), 64'(e.to));
        chk("done_pulse", 64'(done), 64'(!e.to));
        chk("rdData", 64'(rdData), 64'(e.rd));
        chk("setup_cycles", 64'(set_n), 64'(SETUP));
        chk("demand_cycles", 64'(dem_n), 64'(e.dem));
        chk("release_cycles", 64'(rel_n), 64'(e.rel));
        chk("end_drop", 64'({EBUS_CS, EBUS_FUNC, EBUS_DEMAND, adToEBUS_L, adToEBUS_R}), 64'(0));
      end
      set_n = 0; dem_n = 0; rel_n = 0;
    end else if (busy) begin
      if (EBUS_DEMAND) begin
        if (dem_n == 0 && expq.size() > 0) begin
          chk("cs", 64'(EBUS_CS), 64'(expq[0].ctl));
          chk("func", 64'(EBUS_FUNC), 64'(expq[0].fn));
          chk("adL", 64'(adToEBUS_L), 64'(expq[0].wr));
          chk("adR", 64'(adToEBUS_R), 64'(expq[0].wr));
        end
        dem_n++;
      end else if (dem_n == 0) begin
        set_n++;
      end else begin
        rel_n++;
      end
    end
  end

  task automatic start(input bit wr, input bit [2:0] fn, input bit [6:0] ctl,
                       input int mode, input bit [35:0] data, input int n_exp);
    @(posedge eboxClk); #1;
    dev_mode = mode;
    dev_data = data;
    isWrite  = wr;
    func     = fn;
    ctlNum   = ctl;
    req      = 1'b1;
    for (int i = 0; i < n_exp; i++) expq.push_back(predict(wr, fn, ctl, mode, data));
  endtask

  task automatic wait_pulse(input bit poke);
    bit poked = 1'b0;
    bit seen  = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge eboxClk);
      if (req && poked) req = 1'b0;
      if (poke && !poked && EBUS_DEMAND) begin req = 1'b1; poked = 1'b1; end
      if (done || timeout) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL pulse_wait: got no done/timeout within 200 cycles, expected one");
    end
    req = 1'b0;
  endtask

  task automatic xfer(input bit wr, input bit [2:0] fn, input bit [6:0] ctl,
                      input int mode, input bit [35:0] data, input bit poke);
    start(wr, fn, ctl, mode, data, 1);
    @(posedge eboxClk); #1;
    req = 1'b0;
    wait_pulse(poke);
    @(negedge eboxClk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge eboxClk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outs", 64'({done, timeout, adToEBUS_L, adToEBUS_R, EBUS_CS, EBUS_FUNC, EBUS_DEMAND}), 64'(0));
    chk("rst_rdData", 64'(rdData), 64'(0));
    eboxReset_n = 1'b1;
    repeat (2) @(negedge eboxClk);

    // Directed write, then read, then a write that must not touch rdData
    xfer(1'b1, 3'd3, 7'o14, MODE_OK, 36'o000000000000, 1'b0);
    xfer(1'b0, 3'd5, 7'o101, MODE_OK, 36'o123456701234, 1'b0);
    xfer(1'b1, 3'd1, 7'o77, MODE_OK, 36'o777777777777, 1'b0);

    // Reset in the middle of DEMAND of a read
    @(posedge eboxClk); #1;
    dev_mode = MODE_NEVER; isWrite = 1'b0; func = 3'd2; ctlNum = 7'o33; req = 1'b1;
    @(posedge eboxClk); #1;
    req = 1'b0;
    for (int n = 0; n < 20 && !EBUS_DEMAND; n++) @(negedge eboxClk);
    chk("rst_test_in_demand", 64'(EBUS_DEMAND), 64'(1));
    repeat (2) @(negedge eboxClk);
    #2;
    eboxReset_n = 1'b0;
    #1;
    model_rd = '0;
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_ctl", 64'({EBUS_CS, EBUS_FUNC, EBUS_DEMAND, adToEBUS_L, adToEBUS_R}), 64'(0));
    chk("async_rst_pulses", 64'({done, timeout}), 64'(0));
    chk("async_rst_rdData", 64'(rdData), 64'(0));
    repeat (2) @(negedge eboxClk);
    eboxReset_n = 1'b1;
    repeat (5) @(negedge eboxClk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_rdData", 64'(rdData), 64'(0));

    // Timeout in DEMAND, then in RELEASE
    xfer(1'b0, 3'd4, 7'o12, MODE_OK, 36'o707070707070, 1'b0);
    xfer(1'b0, 3'd6, 7'o21, MODE_NEVER, 36'o111111111111, 1'b0);
    xfer(1'b0, 3'd7, 7'o55, MODE_STUCK, 36'o222233334444, 1'b0);

    // req held through completion restarts after exactly one IDLE cycle
    start(1'b0, 3'd2, 7'o66, MODE_OK, 36'o525252525252, 2);
    @(posedge eboxClk);
    wait_pulse(1'b0);
    req = 1'b1;
    @(negedge eboxClk);
    chk("b2b_idle_gap", 64'(busy), 64'(0));
    @(negedge eboxClk);
    chk("b2b_restart", 64'(busy), 64'(1));
    req = 1'b0;
    wait_pulse(1'b0);
    @(negedge eboxClk);

    // Req pulse during DEMAND must not start an extra transfer
    xfer(1'b1, 3'd0, 7'o03, MODE_OK, 36'o0, 1'b1);
    repeat (4) @(negedge eboxClk);
    chk("no_queued_req", 64'(busy), 64'(0));

    // Randomized transfers
    for (int t = 0; t < 30; t++) begin
      int        r;
      int        mode;
      bit [35:0] d;
      r    = $urandom_range(0, 9);
      mode = (r < 7) ? MODE_OK : (r < 9) ? MODE_NEVER : MODE_STUCK;
      d    = 36'({$urandom, $urandom});
      xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
           mode, d, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge eboxClk);
    chk("queue_empty", 64'(expq.size()), 64'(0));
    chk("final_idle", 64'(busy), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
